// File: rtl/divide_sequencer_pkg.sv
// ============================================================================
// Module : divide_sequencer_pkg
// Brief  : Shared types and constants for the divide-by-subtraction sequencer
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package divide_sequencer_pkg;

  // Controller states; explicit 3-bit encoding keeps the state register width fixed
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CHECK   = 3'd2,
    SUB     = 3'd3,
    TEST    = 3'd4,
    RESTORE = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_t;

  // A-register source select encodings (2'b0x selects Q)
  localparam logic [1:0] ASEL_Q   = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b10;
  localparam logic [1:0] ASEL_ALU = 2'b11;

  // Width of the quotient counter
  localparam int COUNT_W = 8;

endpackage : divide_sequencer_pkg

`default_nettype wire

// File: rtl/divide_sequencer_iteration_counter.sv
// ============================================================================
// Module : iteration_counter
// Brief  : 8-bit quotient counter with synchronous clear, increment enable
//          and a terminal flag asserted when the next increment hits MAX_ITER
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module iteration_counter
  import divide_sequencer_pkg::*;
#(
  parameter int MAX_ITER = 127
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_inc,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_at_limit
);

  // Value the counter holds one increment before the iteration guard trips
  localparam logic [COUNT_W-1:0] C_LIMIT_M1 = COUNT_W'(MAX_ITER - 1);

  logic [COUNT_W-1:0] r_count;

  // Count register: clear has priority over increment; otherwise hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count    = r_count;
  // True when Count+1 would equal MAX_ITER, i.e. the current increment is the last allowed
  assign o_at_limit = (r_count == C_LIMIT_M1);

endmodule : iteration_counter

`default_nettype wire

// File: rtl/divide_sequencer.sv
// ============================================================================
// Module : divide_sequencer
// Brief  : Moore controller for unsigned division by repeated subtraction
//          with a single restore step. Count holds the quotient, the external
//          A register holds the remainder on completion.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module divide_sequencer
  import divide_sequencer_pkg::*;
#(
  parameter int MAX_ITER = 127
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_aeq0,
  input  logic               i_apos,
  input  logic               i_qzero,
  output logic               o_aload,
  output logic [1:0]         o_asel,
  output logic               o_sub,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [COUNT_W-1:0] o_count
);

  // The counter must never wrap, and a guard of zero could never be reached
  generate
    if ((MAX_ITER < 1) || (MAX_ITER > 255)) begin : g_bad_max_iter
      $error("divide_sequencer: MAX_ITER must be in 1..255");
    end
  endgenerate

  state_t r_state;
  state_t w_next_state;

  logic w_cnt_clear;
  logic w_cnt_inc;
  logic w_at_limit;

  // Quotient counter: cleared on LOAD, bumped on every non-negative TEST
  assign w_cnt_clear = (r_state == LOAD);
  assign w_cnt_inc   = (r_state == TEST) && i_apos;

  iteration_counter #(
    .MAX_ITER (MAX_ITER)
  ) u_iteration_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_cnt_clear),
    .i_inc      (w_cnt_inc),
    .o_count    (o_count),
    .o_at_limit (w_at_limit)
  );

  // State register; async reset returns straight to IDLE mid-operation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; flags are only looked at in CHECK and TEST
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next_state = i_qzero ? ERR : LOAD;
        end
      end
      LOAD: begin
        w_next_state = CHECK;
      end
      CHECK: begin
        if (!i_apos) begin
          w_next_state = ERR;
        end else if (i_aeq0) begin
          w_next_state = DONE;
        end else begin
          w_next_state = SUB;
        end
      end
      SUB: begin
        w_next_state = TEST;
      end
      TEST: begin
        // Exact termination takes priority over the iteration guard
        if (!i_apos) begin
          w_next_state = RESTORE;
        end else if (i_aeq0) begin
          w_next_state = DONE;
        end else if (w_at_limit) begin
          w_next_state = ERR;
        end else begin
          w_next_state = SUB;
        end
      end
      RESTORE: begin
        w_next_state = DONE;
      end
      DONE: begin
        w_next_state = IDLE;
      end
      ERR: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Moore output decode from the state register only
  always_comb begin
    o_aload = 1'b0;
    o_asel  = ASEL_Q;
    o_sub   = 1'b0;
    o_busy  = (r_state != IDLE);
    o_done  = 1'b0;
    o_error = 1'b0;
    case (r_state)
      LOAD: begin
        o_aload = 1'b1;
        o_asel  = ASEL_IN;
      end
      SUB: begin
        o_aload = 1'b1;
        o_asel  = ASEL_ALU;
        o_sub   = 1'b1;
      end
      RESTORE: begin
        o_aload = 1'b1;
        o_asel  = ASEL_ALU;
        o_sub   = 1'b0;
      end
      DONE: begin
        o_done = 1'b1;
      end
      ERR: begin
        o_done  = 1'b1;
        o_error = 1'b1;
      end
      default: begin
        o_aload = 1'b0;
      end
    endcase
  end

endmodule : divide_sequencer

`default_nettype wire

// File: doc/divide_sequencer.md
# divide_sequencer

Moore-FSM controller that drives the 8-bit A-register datapath (A register, Input/ALU/Q select muxes, add/subtract unit, Aeq0/Apos flags) to perform unsigned division by repeated subtraction with restore. On Start it loads the dividend from Input and repeatedly computes A ← A − Q while A stays non-negative, counting iterations. If the last subtraction overshoots, it restores with A ← A + Q. At completion Count holds the quotient and the A register holds the remainder.

## Interface
Parameters:
- MAX_ITER, default 127: iteration guard; reaching it without termination is an error.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only in IDLE
- Aeq0  in  1  datapath flag: A == 0
- Apos  in  1  datapath flag: A[7] == 0
- Qzero  in  1  divisor Q == 0, supplied by the surrounding logic
- Aload  out  1  A register load enable
- Asel  out  2  A source select: 2'b10 Input, 2'b11 add/sub result, 2'b0x Q
- Sub  out  1  1 = subtract (A−Q), 0 = add (A+Q)
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle completion pulse
- Error  out  1  one-cycle pulse, coincident with Done, on a failed operation
- Count  out  8  quotient; holds its value until the next accepted Start

## Operation
States and transitions:
- IDLE: all strobes low.
  - Start & !Qzero → LOAD.
  - Start & Qzero → ERR.
- LOAD: Aload=1, Asel=10. Count ← 0. → CHECK.
- CHECK: Aload=0.
  - !Apos → ERR (negative dividend).
  - Aeq0 → DONE.
  - Otherwise → SUB.
- SUB: Aload=1, Asel=11, Sub=1. → TEST.
- TEST: Aload=0.
  - !Apos → RESTORE.
  - Apos: Count ← Count+1, then:
    - Aeq0 → DONE.
    - Count+1 == MAX_ITER → ERR.
    - Otherwise → SUB.
- RESTORE: Aload=1, Asel=11, Sub=0. → DONE.
- DONE: Done=1. → IDLE.
- ERR: Done=1, Error=1. → IDLE. Count holds its partial value.

Output and input rules:
- Outputs are decoded from the state register only. Count is the only datapath-like register inside the block.
- Start outside IDLE is ignored. Start held high re-triggers immediately after DONE or ERR returns to IDLE.
- Count is 8-bit unsigned and never wraps, because MAX_ITER ≤ 255 is enforced by parameter check.
- Flags are consumed only in CHECK and TEST, i.e. the cycle after an A load.
- Reset asserted mid-operation: state → IDLE and all outputs → 0 immediately. The A register contents are not this block's concern.

## Timing
- Reset values: Aload 0, Asel 2'b00, Sub 0, Busy 0, Done 0, Error 0, Count 8'd0, state IDLE.
- Start is accepted at edge 0. LOAD occupies cycle 1 and CHECK occupies cycle 2.
- SUB/TEST pairs start at cycle 3.
- Exact division, quotient q: Done in cycle 2q+3. A zero dividend gives Done in cycle 3.
- Non-exact division, quotient q: q+1 SUB/TEST pairs, RESTORE in cycle 2q+5, Done in cycle 2q+6.
- Divide by zero: Error and Done in cycle 1.
- Busy rises in cycle 1 and falls the cycle after Done.

## Structure
- Shared package contains:
  - state enum: IDLE, LOAD, CHECK, SUB, TEST, RESTORE, DONE, ERR;
  - Asel constants: ASEL_Q=2'b00, ASEL_IN=2'b10, ASEL_ALU=2'b11.
- One sub-module, iteration_counter: 8-bit, with synchronous clear, increment enable, and terminal-compare against MAX_ITER.

## Test plan
- Dividend 7, Q=2 → Done in cycle 12, Count=3, A=1, Error=0. Sequence: one RESTORE with Sub=0.
- Dividend 6, Q=2 → Done in cycle 9, Count=3, A=0, no RESTORE state visited.
- Dividend 0, Q=5 → Done in cycle 3, Count=0, Error=0.
- Qzero=1 with Start → Done=Error=1 in cycle 1, Aload never asserted.
- Dividend 8'h90 (negative) → Error in cycle 3. Separately, MAX_ITER=4 with 100/1 → Error after the 4th increment, Count=4.
- Reset pulled low during the TEST of a 100/3 run → all outputs 0 asynchronously. Start afterwards with 9/3 → correct Count=3.
